// File: rtl/wconv_fifo_pkg.sv
// rtl/wconv_fifo_pkg.sv - width helpers shared by the width-down-converting FIFO
package wconv_fifo_pkg;

    function automatic int calc_in_width(input int out_width, input int ratio);
        return out_width * ratio;
    endfunction

    function automatic int clog2_int(input int value);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < value) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // A one-subword word still needs a 1-bit index register.
    function automatic int sub_idx_width(input int ratio);
        return (ratio <= 1) ? 1 : clog2_int(ratio);
    endfunction

endpackage

// File: rtl/wconv_sdp_ram.sv
// rtl/wconv_sdp_ram.sv - simple dual-port RAM, registered read, no reset
module wconv_sdp_ram #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_wconv_prefetch_fifo.sv
// rtl/sync_wconv_prefetch_fifo.sv - wide-to-narrow FWFT FIFO with 2-entry prefetch stage
module sync_wconv_prefetch_fifo
    import wconv_fifo_pkg::*;
#(
    parameter int OUT_WIDTH  = 16,
    parameter int RATIO      = 4,
    parameter int ADDR_WIDTH = 7,
    parameter bit LSB_FIRST  = 1'b1,
    parameter int AF_MARGIN  = 4,
    parameter int AE_MARGIN  = 1
) (
    input  logic                                      clk_i,
    input  logic                                      rst_n_i,
    input  logic                                      flush_i,
    input  logic                                      wr_en_i,
    input  logic [calc_in_width(OUT_WIDTH, RATIO)-1:0] wr_data_i,
    output logic                                      wr_rdy_o,
    input  logic                                      rd_en_i,
    output logic                                      rd_vld_o,
    output logic [OUT_WIDTH-1:0]                      rd_data_o,
    output logic                                      rd_last_o,
    output logic [ADDR_WIDTH+1:0]                     level_o,
    output logic                                      almost_full_o,
    output logic                                      almost_empty_o
);

    localparam int IN_WIDTH = calc_in_width(OUT_WIDTH, RATIO);
    localparam int SUB_W    = sub_idx_width(RATIO);
    localparam int DEPTH    = 2**ADDR_WIDTH;
    localparam int CNT_W    = ADDR_WIDTH + 1;
    localparam int LVL_W    = ADDR_WIDTH + 2;

    localparam logic [SUB_W-1:0] LAST_IDX  = SUB_W'(RATIO - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_THRESH = CNT_W'(DEPTH - AF_MARGIN);
    localparam logic [LVL_W-1:0] AE_THRESH = LVL_W'(AE_MARGIN);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      mem_cnt_q, mem_cnt_d;
    logic                  ram_vld_q, ram_vld_d;
    logic                  r_vld_q, r_vld_d;
    logic                  o_vld_q, o_vld_d;
    logic [IN_WIDTH-1:0]   r_data_q, r_data_d;
    logic [IN_WIDTH-1:0]   o_data_q, o_data_d;
    logic [SUB_W-1:0]      sub_idx_q, sub_idx_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  af_q, af_d;
    logic                  ae_q, ae_d;

    logic                  wr_rdy;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  o_rel;
    logic                  ram_rd;
    logic [1:0]            occ;
    logic [IN_WIDTH-1:0]   ram_rdata;
    logic [SUB_W-1:0]      sel;

    wconv_sdp_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (IN_WIDTH)
    ) u_ram (
        .clk_i     (clk_i),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_data_i),
        .rd_en_i   (ram_rd),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (ram_rdata)
    );

    assign wr_rdy = (mem_cnt_q != DEPTH_CNT);
    assign wr_acc = wr_en_i & wr_rdy & ~flush_i;
    assign rd_acc = rd_en_i & o_vld_q;
    assign o_rel  = rd_acc & (sub_idx_q == LAST_IDX);

    // R, O and the in-flight read together never exceed two words, so a read
    // may launch whenever fewer than two are committed or O retires this cycle.
    assign occ    = 2'(ram_vld_q) + 2'(r_vld_q) + 2'(o_vld_q);
    assign ram_rd = (mem_cnt_q != '0) & ((occ != 2'd2) | o_rel);

    always_comb begin
        wr_ptr_d  = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = ram_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        mem_cnt_d = mem_cnt_q + CNT_W'(wr_acc) - CNT_W'(ram_rd);
        ram_vld_d = ram_rd;
        r_vld_d   = r_vld_q;
        r_data_d  = r_data_q;
        o_vld_d   = o_vld_q;
        o_data_d  = o_data_q;
        sub_idx_d = sub_idx_q;
        level_d   = level_q + LVL_W'(wr_acc) - LVL_W'(o_rel);

        if (!o_vld_q || o_rel) begin
            if (r_vld_q) begin
                o_vld_d  = 1'b1;
                o_data_d = r_data_q;
                r_vld_d  = ram_vld_q;
                if (ram_vld_q) begin
                    r_data_d = ram_rdata;
                end
            end else if (ram_vld_q) begin
                o_vld_d  = 1'b1;
                o_data_d = ram_rdata;
            end else begin
                o_vld_d  = 1'b0;
            end
        end else if (ram_vld_q) begin
            r_vld_d  = 1'b1;
            r_data_d = ram_rdata;
        end

        if (rd_acc) begin
            sub_idx_d = o_rel ? '0 : sub_idx_q + SUB_W'(1);
        end

        // Flush lands on the reset state; the in-flight read is simply dropped.
        if (flush_i) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            mem_cnt_d = '0;
            ram_vld_d = 1'b0;
            r_vld_d   = 1'b0;
            r_data_d  = '0;
            o_vld_d   = 1'b0;
            o_data_d  = '0;
            sub_idx_d = '0;
            level_d   = '0;
        end

        af_d = (mem_cnt_d >= AF_THRESH);
        ae_d = (level_d <= AE_THRESH);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mem_cnt_q <= '0;
            ram_vld_q <= 1'b0;
            r_vld_q   <= 1'b0;
            r_data_q  <= '0;
            o_vld_q   <= 1'b0;
            o_data_q  <= '0;
            sub_idx_q <= '0;
            level_q   <= '0;
            af_q      <= 1'b0;
            ae_q      <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mem_cnt_q <= mem_cnt_d;
            ram_vld_q <= ram_vld_d;
            r_vld_q   <= r_vld_d;
            r_data_q  <= r_data_d;
            o_vld_q   <= o_vld_d;
            o_data_q  <= o_data_d;
            sub_idx_q <= sub_idx_d;
            level_q   <= level_d;
            af_q      <= af_d;
            ae_q      <= ae_d;
        end
    end

    assign sel = LSB_FIRST ? sub_idx_q : LAST_IDX - sub_idx_q;

    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (SUB_W'(i) == sel) begin
                rd_data_o = o_data_q[i*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    assign wr_rdy_o       = wr_rdy;
    assign rd_vld_o       = o_vld_q;
    assign rd_last_o      = o_vld_q & (sub_idx_q == LAST_IDX);
    assign level_o        = level_q;
    assign almost_full_o  = af_q;
    assign almost_empty_o = ae_q;

endmodule

// File: tb/tb_sync_wconv_prefetch_fifo.sv
// tb/tb_sync_wconv_prefetch_fifo.sv - directed self-checking bench for sync_wconv_prefetch_fifo
module tb_sync_wconv_prefetch_fifo;

    typedef struct {
        logic        wr_en;
        logic [63:0] wr_data;
        logic        rd_en;
        logic        flush;
        logic        exp_vld;
        logic [15:0] exp_data;
        logic [15:0] exp_data_b;
        logic        exp_last;
        logic [8:0]  exp_level;
        logic        exp_rdy;
        logic        exp_ae;
        logic        exp_af;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, wr_en, rd_en;
    logic [63:0] wr_data;

    logic        a_wr_rdy, a_rd_vld, a_rd_last, a_af, a_ae;
    logic [15:0] a_rd_data;
    logic [8:0]  a_level;
    logic        b_wr_rdy, b_rd_vld, b_rd_last, b_af, b_ae;
    logic [15:0] b_rd_data;
    logic [8:0]  b_level;

    logic        c_flush, c_wr_en, c_rd_en;
    logic [15:0] c_wr_data;
    logic        c_wr_rdy, c_rd_vld, c_rd_last, c_af, c_ae;
    logic [15:0] c_rd_data;
    logic [8:0]  c_level;

    int tests = 0;
    int fails = 0;
    vec_t vecs[16];

    always #5 clk = ~clk;

    sync_wconv_prefetch_fifo u_dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .wr_en_i(wr_en), .wr_data_i(wr_data),
        .wr_rdy_o(a_wr_rdy), .rd_en_i(rd_en), .rd_vld_o(a_rd_vld), .rd_data_o(a_rd_data),
        .rd_last_o(a_rd_last), .level_o(a_level), .almost_full_o(a_af), .almost_empty_o(a_ae)
    );

    sync_wconv_prefetch_fifo #(.LSB_FIRST(1'b0)) u_dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .wr_en_i(wr_en), .wr_data_i(wr_data),
        .wr_rdy_o(b_wr_rdy), .rd_en_i(rd_en), .rd_vld_o(b_rd_vld), .rd_data_o(b_rd_data),
        .rd_last_o(b_rd_last), .level_o(b_level), .almost_full_o(b_af), .almost_empty_o(b_ae)
    );

    sync_wconv_prefetch_fifo #(.RATIO(1)) u_dut_c (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(c_flush), .wr_en_i(c_wr_en), .wr_data_i(c_wr_data),
        .wr_rdy_o(c_wr_rdy), .rd_en_i(c_rd_en), .rd_vld_o(c_rd_vld), .rd_data_o(c_rd_data),
        .rd_last_o(c_rd_last), .level_o(c_level), .almost_full_o(c_af), .almost_empty_o(c_ae)
    );

    function automatic logic [15:0] sw(input int i, input int s);
        return 16'((i << 8) | (s << 4) | 10);
    endfunction

    function automatic logic [63:0] wide(input int i);
        return {sw(i, 3), sw(i, 2), sw(i, 1), sw(i, 0)};
    endfunction

    function automatic vec_t mkv(input logic we, input logic [63:0] wd, input logic re, input logic fl,
                                 input logic vld, input logic [15:0] d, input logic [15:0] db,
                                 input logic last, input int lvl, input logic rdy, input logic ae,
                                 input logic af);
        vec_t v;
        v.wr_en = we; v.wr_data = wd; v.rd_en = re; v.flush = fl;
        v.exp_vld = vld; v.exp_data = d; v.exp_data_b = db; v.exp_last = last;
        v.exp_level = 9'(lvl); v.exp_rdy = rdy; v.exp_ae = ae; v.exp_af = af;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [63:0] wd, input logic re, input logic fl);
        wr_en = we; wr_data = wd; rd_en = re; flush = fl;
    endtask

    initial begin
        logic [63:0] w1;
        int          n, lvl;
        w1 = 64'h4444_3333_2222_1111;
        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        c_flush = 0; c_wr_en = 0; c_rd_en = 0; c_wr_data = 0;

        vecs[0]  = mkv(1, w1,       1, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 1, 0);
        vecs[1]  = mkv(0, 0,        1, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 1, 0);
        vecs[2]  = mkv(0, 0,        1, 0, 1, 16'h1111, 16'h4444, 0, 1, 1, 1, 0);
        vecs[3]  = mkv(0, 0,        1, 0, 1, 16'h2222, 16'h3333, 0, 1, 1, 1, 0);
        vecs[4]  = mkv(0, 0,        1, 0, 1, 16'h3333, 16'h2222, 0, 1, 1, 1, 0);
        vecs[5]  = mkv(0, 0,        1, 0, 1, 16'h4444, 16'h1111, 1, 1, 1, 1, 0);
        vecs[6]  = mkv(0, 0,        1, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 0);
        vecs[7]  = mkv(1, wide(2),  1, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 1, 0);
        vecs[8]  = mkv(1, wide(3),  1, 0, 0, 16'h0000, 16'h0000, 0, 2, 1, 0, 0);
        vecs[9]  = mkv(0, 0,        1, 0, 1, sw(2, 0), sw(2, 3), 0, 2, 1, 0, 0);
        vecs[10] = mkv(0, 0,        1, 0, 1, sw(2, 1), sw(2, 2), 0, 2, 1, 0, 0);
        vecs[11] = mkv(0, 0,        1, 0, 1, sw(2, 2), sw(2, 1), 0, 2, 1, 0, 0);
        vecs[12] = mkv(0, 0,        1, 0, 1, sw(2, 3), sw(2, 0), 1, 2, 1, 0, 0);
        vecs[13] = mkv(1, wide(4),  1, 0, 1, sw(3, 0), sw(3, 3), 0, 2, 1, 0, 0);
        vecs[14] = mkv(0, 0,        0, 0, 1, sw(3, 0), sw(3, 3), 0, 2, 1, 0, 0);
        vecs[15] = mkv(0, 0,        1, 0, 1, sw(3, 1), sw(3, 2), 0, 2, 1, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check("reset wr_rdy", a_wr_rdy, 1);
        check("reset rd_vld", a_rd_vld, 0);
        check("reset rd_data", a_rd_data, 0);
        check("reset rd_last", a_rd_last, 0);
        check("reset level", a_level, 0);
        check("reset almost_full", a_af, 0);
        check("reset almost_empty", a_ae, 1);
        rst_n = 1'b1;

        for (int r = 0; r < 16; r++) begin
            drive(vecs[r].wr_en, vecs[r].wr_data, vecs[r].rd_en, vecs[r].flush);
            step();
            check($sformatf("vec%0d rd_vld", r), a_rd_vld, vecs[r].exp_vld);
            check($sformatf("vec%0d rd_last", r), a_rd_last, vecs[r].exp_last);
            check($sformatf("vec%0d level", r), a_level, vecs[r].exp_level);
            check($sformatf("vec%0d wr_rdy", r), a_wr_rdy, vecs[r].exp_rdy);
            check($sformatf("vec%0d almost_empty", r), a_ae, vecs[r].exp_ae);
            check($sformatf("vec%0d almost_full", r), a_af, vecs[r].exp_af);
            if (vecs[r].exp_vld) begin
                check($sformatf("vec%0d rd_data", r), a_rd_data, vecs[r].exp_data);
                check($sformatf("vec%0d msb_first rd_data", r), b_rd_data, vecs[r].exp_data_b);
            end
        end

        drive(0, 0, 1, 0);
        repeat (10) step();
        check("drain level", a_level, 0);
        check("drain rd_vld", a_rd_vld, 0);

        // writes every 4th cycle with continuous reads: no bubble once filled
        for (int c = 0; c < 36; c++) begin
            drive((c % 4 == 0) && (c < 32), wide(10 + c / 4), 1, 0);
            step();
            if (c >= 2 && c <= 33) begin
                n = c - 2;
                check($sformatf("stream c%0d rd_vld", c), a_rd_vld, 1);
                check($sformatf("stream c%0d rd_data", c), a_rd_data, sw(10 + n / 4, n % 4));
                check($sformatf("stream c%0d msb_first rd_data", c), b_rd_data, sw(10 + n / 4, 3 - n % 4));
                check($sformatf("stream c%0d rd_last", c), a_rd_last, (n % 4) == 3);
            end else begin
                check($sformatf("stream c%0d rd_vld", c), a_rd_vld, 0);
            end
        end
        drive(0, 0, 0, 0);

        // RATIO=1: one word per cycle in and out
        for (int c = 0; c < 14; c++) begin
            c_wr_en = (c < 10);
            c_wr_data = 16'(16'hC000 + c);
            c_rd_en = 1'b1;
            step();
            if (c >= 2 && c <= 11) begin
                check($sformatf("r1 c%0d rd_vld", c), c_rd_vld, 1);
                check($sformatf("r1 c%0d rd_data", c), c_rd_data, 16'(16'hC000 + c - 2));
                check($sformatf("r1 c%0d rd_last", c), c_rd_last, 1);
            end else begin
                check($sformatf("r1 c%0d rd_vld", c), c_rd_vld, 0);
            end
        end
        c_wr_en = 0; c_rd_en = 0;
        check("r1 final level", c_level, 0);

        // fill without reading: 128 in RAM plus 2 prefetched
        for (int k = 1; k <= 131; k++) begin
            drive(1, {16'(16'hB000 + k), 32'h0, 16'(16'hA000 + k)}, 0, 0);
            step();
            lvl = (k > 130) ? 130 : k;
            check($sformatf("fill k%0d level", k), a_level, lvl);
            check($sformatf("fill k%0d wr_rdy", k), a_wr_rdy, k < 130);
            check($sformatf("fill k%0d almost_full", k), a_af, lvl >= 126);
            check($sformatf("fill k%0d almost_empty", k), a_ae, lvl <= 1);
        end
        check("fill head rd_data", a_rd_data, 16'hA001);
        check("fill head msb_first rd_data", b_rd_data, 16'hB001);

        drive(0, 0, 0, 1);
        step();
        check("flush full level", a_level, 0);
        check("flush full rd_vld", a_rd_vld, 0);
        check("flush full wr_rdy", a_wr_rdy, 1);
        check("flush full almost_full", a_af, 0);
        check("flush full almost_empty", a_ae, 1);

        // flush with level=10, sub_idx=2 and a coinciding write
        for (int k = 0; k < 10; k++) begin
            drive(1, wide(20 + k), 0, 0);
            step();
        end
        drive(0, 0, 0, 0);
        repeat (2) step();
        check("pre-flush level", a_level, 10);
        check("pre-flush rd_data", a_rd_data, sw(20, 0));
        drive(0, 0, 1, 0);
        repeat (2) step();
        check("pre-flush sub2 rd_data", a_rd_data, sw(20, 2));
        check("pre-flush sub2 msb_first rd_data", b_rd_data, sw(20, 1));
        check("pre-flush sub2 level", a_level, 10);
        drive(1, wide(99), 1, 1);
        step();
        check("flush level", a_level, 0);
        check("flush rd_vld", a_rd_vld, 0);
        check("flush rd_last", a_rd_last, 0);
        check("flush almost_empty", a_ae, 1);
        check("flush almost_full", a_af, 0);
        drive(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("post-flush idle%0d rd_vld", k), a_rd_vld, 0);
            check($sformatf("post-flush idle%0d level", k), a_level, 0);
        end
        drive(1, wide(30), 0, 0);
        step();
        check("post-flush write rd_vld k+1", a_rd_vld, 0);
        check("post-flush write level", a_level, 1);
        drive(0, 0, 0, 0);
        step();
        check("post-flush write rd_vld k+2 edge-1", a_rd_vld, 0);
        step();
        check("post-flush write rd_vld", a_rd_vld, 1);
        check("post-flush write rd_data", a_rd_data, sw(30, 0));

        // asynchronous reset mid-word
        drive(0, 0, 1, 0);
        step();
        check("pre-reset sub1 rd_data", a_rd_data, sw(30, 1));
        drive(0, 0, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check("async reset rd_vld", a_rd_vld, 0);
        check("async reset rd_data", a_rd_data, 0);
        check("async reset rd_last", a_rd_last, 0);
        check("async reset level", a_level, 0);
        check("async reset wr_rdy", a_wr_rdy, 1);
        check("async reset almost_empty", a_ae, 1);
        check("async reset almost_full", a_af, 0);
        #2;
        rst_n = 1'b1;
        step();
        drive(1, wide(31), 0, 0);
        step();
        drive(0, 0, 0, 0);
        step();
        check("post-reset rd_vld k+1", a_rd_vld, 0);
        step();
        check("post-reset rd_vld", a_rd_vld, 1);
        check("post-reset rd_data", a_rd_data, sw(31, 0));
        check("post-reset msb_first rd_data", b_rd_data, sw(31, 3));
        check("post-reset level", a_level, 1);
        drive(0, 0, 1, 0);
        repeat (4) step();
        check("post-reset drain rd_vld", a_rd_vld, 0);
        check("post-reset drain level", a_level, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
